memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address and data word width.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port iREN  in  1  instruction-fetch read request, held until ihit.
REQ-006 SHALL have port iaddr  in  ADDR_W  instruction-fetch address.
REQ-007 SHALL have port dREN  in  1  data read request, held until dhit.
REQ-008 SHALL have port dWEN  in  1  data write request, held until dhit.
REQ-009 SHALL have port daddr  in  ADDR_W  data address.
REQ-010 SHALL have port dstore  in  ADDR_W  data write value.
REQ-011 SHALL have port ihit  out  1  one-cycle completion pulse for the instruction fetch.
REQ-012 SHALL have port iload  out  ADDR_W  fetched instruction, valid only while ihit=1.
REQ-013 SHALL have port dhit  out  1  one-cycle completion pulse for the data access.
REQ-014 SHALL have port dload  out  ADDR_W  read data, valid only while dhit=1 on a read.
REQ-015 SHALL have port ramREN  out  1  RAM read strobe.
REQ-016 SHALL have port ramWEN  out  1  RAM write strobe.
REQ-017 SHALL have port ramaddr  out  ADDR_W  RAM address.
REQ-018 SHALL have port ramstore  out  ADDR_W  RAM write data.
REQ-019 SHALL have port ramload  in  ADDR_W  RAM read data.
REQ-020 SHALL have port ramready  in  1  RAM completes the presented access in the cycle this is high.

Function
REQ-021 SHALL implement a three-state FSM, IDLE/IGNT/DGNT, with the state registered and all RAM outputs decoded from the state plus the granted requester's inputs.
REQ-022 SHALL, in IDLE, select DGNT if (dREN|dWEN) and (starve_cnt<STARVE_MAX or !iREN); else IGNT if iREN; else stay in IDLE.
REQ-023 SHALL, in IDLE, drive ramREN=ramWEN=0, ramaddr=0, ramstore=0, ihit=dhit=0, and ignore ramready.
REQ-024 SHALL, in IGNT, drive ramREN=1, ramWEN=0, ramaddr=iaddr; when ramready=1, assert ihit=1 and iload=ramload in the same cycle and go to IDLE next.
REQ-025 SHALL, in DGNT, drive ramaddr=daddr, ramWEN=dWEN, ramREN=dREN&!dWEN (write wins if both are set), ramstore=dstore; when ramready=1, assert dhit=1, set dload=ramload (reads only, else 0), and go to IDLE next.
REQ-026 SHALL give a minimum latency of one cycle from request (sampled in IDLE) to hit; a requester receives at most one hit per IDLE visit, and back-to-back grants have one IDLE bubble between them.
REQ-027 SHALL, if the granted requester drops its request before ramready, abort to IDLE on the next edge, with no hit and no counter change.
REQ-028 SHALL keep starve_cnt (width clog2(STARVE_MAX+1)) as follows: increment on each dhit while iREN=1, saturating at STARVE_MAX; clear on ihit or on any cycle with iREN=0.
REQ-029 SHALL ensure ihit and dhit are never high in the same cycle, and that iload/dload are 0 whenever their hit is low.
REQ-030 SHALL ignore request changes in iaddr/daddr/dstore mid-grant, passing them through combinationally; requesters hold them stable.

Reset
REQ-031 SHALL, on any rising edge with RST=1, set the state to IDLE and starve_cnt to 0, overriding all other transitions.
REQ-032 SHALL drive every output to 0 from the first edge where RST is sampled high until a grant occurs after RST falls; a reset mid-grant abandons the access without a hit.

Verification
REQ-033 SHALL cover this case: iREN=1, iaddr=0x100, ramready high on the 3rd IGNT cycle, ramload=0x00500093 -> ihit for exactly 1 cycle with iload=0x00500093, then IDLE.
REQ-034 SHALL cover this case: iREN=1 and dWEN=1 raised together, daddr=0x200, dstore=0xDEADBEEF -> DGNT first with ramWEN=1, ramstore=0xDEADBEEF, then IGNT after one IDLE bubble.
REQ-035 SHALL cover this case: STARVE_MAX=4, dREN held continuously, iREN held, ramready=1 always -> 4 dhits, then an ihit, then data grants resume with starve_cnt=0.
REQ-036 SHALL cover this case: dREN=1 and dWEN=1 simultaneously -> ramWEN=1, ramREN=0, and dload=0 at dhit.
REQ-037 SHALL cover this case: RST pulsed for 1 cycle during DGNT with ramready=0 -> next cycle all outputs 0 and state IDLE; no dhit, no RAM strobe until re-granted.
REQ-038 SHALL cover this case: iREN dropped mid-IGNT before ramready -> IDLE next cycle with no ihit; a pending dREN is then granted.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: instruction fetch and data port share one RAM.
// Data wins by default; a starvation counter forces an instruction grant.
module memory_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              ihit,
    output logic [ADDR_W-1:0] iload,
    output logic              dhit,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic              ramready
);

    localparam int CW =
        (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;

    logic d_req;
    logic d_rd;
    logic d_ok;

    assign d_req = dREN | dWEN;
    // A simultaneous read and write request is treated as a write.
    assign d_rd  = dREN & ~dWEN;
    assign d_ok  = (starve_cnt < SMAX) | ~iREN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        state_next = state;
        ihit       = 1'b0;
        iload      = '0;
        dhit       = 1'b0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        unique case (state)
            IDLE: begin
                if (d_req && d_ok) begin
                    state_next = DGNT;
                end else if (iREN) begin
                    state_next = IGNT;
                end
            end
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_next = IDLE;
                end else if (ramready) begin
                    ihit       = 1'b1;
                    iload      = ramload;
                    state_next = IDLE;
                end
            end
            DGNT: begin
                ramREN   = d_rd;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_next = IDLE;
                end else if (ramready) begin
                    dhit       = 1'b1;
                    dload      = d_rd ? ramload : '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counts data completions that overtook a waiting fetch.
    always_comb begin
        starve_next = starve_cnt;
        if (ihit || !iREN) begin
            starve_next = '0;
        end else if (dhit && (starve_cnt < SMAX)) begin
            starve_next = starve_cnt + CW'(1);
        end
    end

    a_one_hit : assert property (
        @(posedge CLK) disable iff (RST) !(ihit && dhit)
    );

    a_one_strobe : assert property (
        @(posedge CLK) disable iff (RST) !(ramREN && ramWEN)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run
// checked against transaction-level rules and a functional RAM model.
module tb_memory_arbiter;

    localparam int SM = 4;
    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [AW-1:0] dstore;
    logic          ihit;
    logic [AW-1:0] iload;
    logic          dhit;
    logic [AW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [AW-1:0] ramstore;
    logic [AW-1:0] ramload;
    logic          ramready;

    logic          ram_model;
    logic [AW-1:0] ramload_d;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [AW-1:0] mem_f(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    assign ramload = ram_model ? mem_f(ramaddr) : ramload_d;

    always #5 CLK = ~CLK;

    memory_arbiter #(
        .STARVE_MAX(SM),
        .ADDR_W    (AW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .ihit    (ihit),
        .iload   (iload),
        .dhit    (dhit),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramready(ramready)
    );

    function automatic logic [131:0] outs();
        return {ihit, iload, dhit, dload,
                ramREN, ramWEN, ramaddr, ramstore};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramready = 1'b0;
    endtask

    task automatic test_reset();
        iREN     = 1'b1;
        iaddr    = 32'h40;
        dREN     = 1'b1;
        daddr    = 32'h80;
        ramready = 1'b1;
        step();
        step();
        @(negedge CLK);
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h want 0", outs());
        end
        step();
        RST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h want 0", outs());
        end
        step();
    endtask

    task automatic test_ifetch();
        iREN      = 1'b1;
        iaddr     = 32'h100;
        ramload_d = 32'h0050_0093;
        @(negedge CLK);
        n_checks++;
        if ({ihit, ramREN} !== 2'b00) begin
            n_fail++;
            $display("FAIL ifetch_idle: ihit,ramREN=%b want 00",
                     {ihit, ramREN});
        end
        step();
        for (int c = 1; c <= 3; c++) begin
            ramready = (c == 3);
            @(negedge CLK);
            n_checks++;
            if ({ihit, dhit, ramREN, ramWEN} !== {c == 3, 3'b010} ||
                ramaddr !== 32'h100 ||
                iload !== ((c == 3) ? 32'h0050_0093 : 32'h0)) begin
                n_fail++;
                $display("FAIL ifetch_c%0d: hits/strb=%b addr=%h iload=%h",
                         c, {ihit, dhit, ramREN, ramWEN}, ramaddr, iload);
            end
            step();
        end
        iREN     = 1'b0;
        ramready = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({ihit, ramREN} !== 2'b00) begin
            n_fail++;
            $display("FAIL ifetch_after: ihit,ramREN=%b want 00",
                     {ihit, ramREN});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_write_priority();
        iREN      = 1'b1;
        iaddr     = 32'h104;
        dWEN      = 1'b1;
        daddr     = 32'h200;
        dstore    = 32'hDEAD_BEEF;
        ramready  = 1'b1;
        ramload_d = 32'h0000_0013;
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            n_fail++;
            $display("FAIL wpri_idle: hits/strb=%b want 0000",
                     {ihit, dhit, ramREN, ramWEN});
        end
        step();
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0101 ||
            ramaddr !== 32'h200 || ramstore !== 32'hDEAD_BEEF ||
            dload !== '0) begin
            n_fail++;
            $display("FAIL wpri_dgnt: hits/strb=%b addr=%h st=%h dl=%h",
                     {ihit, dhit, ramREN, ramWEN}, ramaddr, ramstore, dload);
        end
        step();
        dWEN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            n_fail++;
            $display("FAIL wpri_bubble: hits/strb=%b want 0000",
                     {ihit, dhit, ramREN, ramWEN});
        end
        step();
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b1010 ||
            ramaddr !== 32'h104 || iload !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL wpri_ignt: hits/strb=%b addr=%h iload=%h",
                     {ihit, dhit, ramREN, ramWEN}, ramaddr, iload);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_starvation();
        int nh = 0;
        logic prev_hit = 1'b0;
        logic exp_i;
        iREN      = 1'b1;
        iaddr     = 32'h108;
        dREN      = 1'b1;
        daddr     = 32'h240;
        ramready  = 1'b1;
        ramload_d = 32'h0BAD_C0DE;
        for (int c = 0; c < 40 && nh < 10; c++) begin
            @(negedge CLK);
            if (ihit || dhit) begin
                exp_i = ((nh % (SM + 1)) == SM);
                n_checks++;
                if ({ihit, dhit} !== {exp_i, !exp_i}) begin
                    n_fail++;
                    $display("FAIL starve_order%0d: i,d=%b want %b",
                             nh, {ihit, dhit}, {exp_i, !exp_i});
                end
                n_checks++;
                if (prev_hit || (ihit ? iload : dload) !== ramload_d) begin
                    n_fail++;
                    $display("FAIL starve_data%0d: prev=%b il=%h dl=%h",
                             nh, prev_hit, iload, dload);
                end
                nh++;
            end
            prev_hit = ihit | dhit;
            step();
        end
        n_checks++;
        if (nh != 10) begin
            n_fail++;
            $display("FAIL starve_timeout: hits=%0d want 10", nh);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_rw_conflict();
        dREN      = 1'b1;
        dWEN      = 1'b1;
        daddr     = 32'h300;
        dstore    = 32'h1234_5678;
        ramready  = 1'b1;
        ramload_d = 32'hCAFE_F00D;
        @(negedge CLK);
        n_checks++;
        if ({dhit, ramREN, ramWEN} !== 3'b000) begin
            n_fail++;
            $display("FAIL rw_idle: d,ren,wen=%b want 000",
                     {dhit, ramREN, ramWEN});
        end
        step();
        @(negedge CLK);
        n_checks++;
        if ({dhit, ramREN, ramWEN} !== 3'b101 || dload !== '0 ||
            ramaddr !== 32'h300 || ramstore !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rw_grant: d,ren,wen=%b dl=%h addr=%h st=%h",
                     {dhit, ramREN, ramWEN}, dload, ramaddr, ramstore);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_grant();
        dREN  = 1'b1;
        daddr = 32'h400;
        @(negedge CLK);
        step();
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({dhit, ramREN} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstg_dgnt: dhit,ramREN=%b want 01",
                     {dhit, ramREN});
        end
        step();
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL rstg_after: outputs=%h want 0", outs());
        end
        step();
        ramready  = 1'b1;
        ramload_d = 32'h0000_0077;
        @(negedge CLK);
        n_checks++;
        if ({dhit, ramREN} !== 2'b11 || dload !== 32'h77 ||
            ramaddr !== 32'h400) begin
            n_fail++;
            $display("FAIL rstg_regrant: dhit,ramREN=%b dl=%h addr=%h",
                     {dhit, ramREN}, dload, ramaddr);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_iabort();
        iREN  = 1'b1;
        iaddr = 32'h500;
        @(negedge CLK);
        step();
        @(negedge CLK);
        n_checks++;
        if ({ihit, ramREN} !== 2'b01 || ramaddr !== 32'h500) begin
            n_fail++;
            $display("FAIL abort_ignt: ihit,ramREN=%b addr=%h",
                     {ihit, ramREN}, ramaddr);
        end
        step();
        iREN  = 1'b0;
        dREN  = 1'b1;
        daddr = 32'h600;
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_drop: i,d=%b want 00", {ihit, dhit});
        end
        step();
        ramready  = 1'b1;
        ramload_d = 32'h0000_0066;
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle: hits/strb=%b want 0000",
                     {ihit, dhit, ramREN, ramWEN});
        end
        step();
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0110 ||
            ramaddr !== 32'h600 || dload !== 32'h66) begin
            n_fail++;
            $display("FAIL abort_dgrant: hits/strb=%b addr=%h dl=%h",
                     {ihit, dhit, ramREN, ramWEN}, ramaddr, dload);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        int scnt = 0;
        int iw   = 0;
        int dw   = 0;
        int nih  = 0;
        int ndh  = 0;
        logic issue;
        logic ih;
        logic dh;
        logic [AW-1:0] exp_d;
        ram_model = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            issue = (c < 900);
            if (!iREN && issue && $urandom_range(0, 2) == 0) begin
                iREN  = 1'b1;
                iaddr = $urandom;
            end
            if (!dREN && !dWEN && issue &&
                $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0: dREN = 1'b1;
                    1: dWEN = 1'b1;
                    default: begin
                        dREN = 1'b1;
                        dWEN = 1'b1;
                    end
                endcase
                daddr  = $urandom;
                dstore = $urandom;
            end
            ramready = 1'($urandom_range(0, 1));
            @(negedge CLK);
            n_checks++;
            if (ihit && dhit) begin
                n_fail++;
                $display("FAIL rnd_both_hits: cycle %0d", c);
            end
            n_checks++;
            if ((!ihit && iload !== '0) || (!dhit && dload !== '0)) begin
                n_fail++;
                $display("FAIL rnd_idle_load: il=%h dl=%h want 0",
                         iload, dload);
            end
            n_checks++;
            if (ramREN && ramWEN) begin
                n_fail++;
                $display("FAIL rnd_strobes: ren,wen=11 want not both");
            end
            if (ihit) begin
                n_checks++;
                if (iload !== mem_f(iaddr) || !ramready || !iREN) begin
                    n_fail++;
                    $display("FAIL rnd_ihit: il=%h want %h rdy=%b",
                             iload, mem_f(iaddr), ramready);
                end
                nih++;
            end
            if (dhit) begin
                exp_d = (dREN && !dWEN) ? mem_f(daddr) : '0;
                n_checks++;
                if (dload !== exp_d || !ramready) begin
                    n_fail++;
                    $display("FAIL rnd_dhit: dl=%h want %h rdy=%b",
                             dload, exp_d, ramready);
                end
                ndh++;
            end
            if (ramWEN) begin
                n_checks++;
                if (!dWEN || ramaddr !== daddr || ramstore !== dstore) begin
                    n_fail++;
                    $display("FAIL rnd_write: addr=%h st=%h want %h %h",
                             ramaddr, ramstore, daddr, dstore);
                end
            end
            if (dhit && iREN) begin
                n_checks++;
                if (scnt >= SM) begin
                    n_fail++;
                    $display("FAIL rnd_starve: dhits in a row=%0d max %0d",
                             scnt + 1, SM);
                end
            end
            if (ihit || !iREN) begin
                scnt = 0;
            end else if (dhit && scnt < SM) begin
                scnt++;
            end
            iw = (iREN && !ihit) ? iw + 1 : 0;
            dw = ((dREN || dWEN) && !dhit) ? dw + 1 : 0;
            n_checks++;
            if (iw > 64 || dw > 64) begin
                n_fail++;
                $display("FAIL rnd_timeout: iwait=%0d dwait=%0d max 64",
                         iw, dw);
                break;
            end
            ih = ihit;
            dh = dhit;
            step();
            if (ih) begin
                iREN = 1'b0;
            end
            if (dh) begin
                dREN = 1'b0;
                dWEN = 1'b0;
            end
        end
        n_checks++;
        if (nih == 0 || ndh == 0 || iREN || dREN || dWEN) begin
            n_fail++;
            $display("FAIL rnd_drain: ihits=%0d dhits=%0d pending=%b",
                     nih, ndh, {iREN, dREN, dWEN});
        end
        ram_model = 1'b0;
        idle_inputs();
        step();
    endtask

    initial begin
        RST       = 1'b1;
        ram_model = 1'b0;
        ramload_d = '0;
        idle_inputs();
        step();
        test_reset();
        test_ifetch();
        test_write_priority();
        test_starvation();
        test_rw_conflict();
        test_reset_mid_grant();
        test_iabort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
